// File: rtl/mul_pkg.sv
// Shared definitions for the iterative MULT/MULTU sequencer: FSM states and sizes.
package mul_pkg;

  localparam int unsigned MUL_W    = 32;
  localparam int unsigned MUL_ITER = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_seq_ctrl_row.sv
// TP_ROW: one partial-product row, PO/CO = PI + (X & Y) + CI, purely combinational.
module TP_ROW #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] X_ROW,
  input  logic             Y_ROW,
  input  logic [WIDTH-1:0] PI_ROW,
  input  logic             CI_ROW,
  output logic [WIDTH-1:0] PO_ROW,
  output logic             CO_ROW
);

  logic [WIDTH-1:0] w_pp;

  always_comb begin
    w_pp             = X_ROW & {WIDTH{Y_ROW}};
    {CO_ROW, PO_ROW} = {1'b0, PI_ROW} + {1'b0, w_pp} + {{WIDTH{1'b0}}, CI_ROW};
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative 32x32->64 multiplier sequencer, one multiplier bit retired per cycle.
// Optional signed mode (MULT) is enabled by defining MUL_SIGNED_EN.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef MUL_SIGNED_EN
  input  logic             signed_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] w_po;
  logic             w_co;
  logic [WIDTH-1:0] w_a_ld;
  logic [WIDTH-1:0] w_b_ld;
  logic [2*WIDTH-1:0] w_result;

  TP_ROW #(.WIDTH(WIDTH)) u_row (
    .X_ROW  (r_mcand),
    .Y_ROW  (r_mplier[0]),
    .PI_ROW (r_acc),
    .CI_ROW (1'b0),
    .PO_ROW (w_po),
    .CO_ROW (w_co)
  );

`ifdef MUL_SIGNED_EN
  logic r_neg;
  logic w_a_neg;
  logic w_b_neg;

  // Magnitudes are loaded; |0x80000000| wraps to itself, which is the correct unsigned value.
  always_comb begin
    w_a_neg  = signed_i & a_i[WIDTH-1];
    w_b_neg  = signed_i & b_i[WIDTH-1];
    w_a_ld   = w_a_neg ? (~a_i + 1'b1) : a_i;
    w_b_ld   = w_b_neg ? (~b_i + 1'b1) : b_i;
    w_result = r_neg ? (~{r_acc, r_mplier} + 1'b1) : {r_acc, r_mplier};
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_neg <= 1'b0;
    else if (r_state == S_IDLE && start_i)
      r_neg <= w_a_neg ^ w_b_neg;
  end
`else
  always_comb begin
    w_a_ld   = a_i;
    w_b_ld   = b_i;
    w_result = {r_acc, r_mplier};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      hi_o     <= '0;
      lo_o     <= '0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_mcand  <= w_a_ld;
            r_mplier <= w_b_ld;
            r_acc    <= '0;
            r_cnt    <= '0;
            busy_o   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          // {acc, mplier} <= {CO, PO, mplier} >> 1
          r_acc    <= {w_co, w_po[WIDTH-1:1]};
          r_mplier <= {w_po[0], r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(MUL_ITER - 1))
            r_state <= S_DONE;
        end
        S_DONE: begin
          hi_o    <= w_result[2*WIDTH-1:WIDTH];
          lo_o    <= w_result[WIDTH-1:0];
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
